mem_latency_responder: RTL and testbench

- Responder end of the data-memory interface driven by the pipeline's memory-access stage: accepts word read/write requests (addr, data_in, enable, wr) and completes them after a programmable number of cycles.
- Replaces the ideal single-cycle memory with a realistic multi-cycle responder that signals `stall` while busy and pulses `done` on completion.
- Sits between the memory-access stage and the backing word array. The hazard unit consumes `stall` to freeze the pipeline.

---
 rtl/mem_pkg.sv | 10 +
 rtl/mem_word_array.sv | 22 ++
 rtl/mem_latency_responder.sv | 109 ++++++++++
 tb/tb_mem_latency_responder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and widths for the multi-cycle data-memory responder.
package mem_pkg;
   localparam int unsigned WORD_W = 16;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01
   } state_e;
endpackage

// File: rtl/mem_word_array.sv
// Single-port word array: synchronous write, asynchronous read.
module mem_word_array
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[idx] <= wdata;
   end

   assign rdata = r_mem[idx];
endmodule

// File: rtl/mem_latency_responder.sv
// Memory responder: accepts one word request, completes it LATENCY edges later,
// holding stall while in flight and pulsing done on completion.
module mem_latency_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] data_in,
   input  logic              enable,
   input  logic              wr,
   output logic [WORD_W-1:0] data_out,
   output logic              done,
   output logic              stall
);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   state_e            r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
   logic              r_done, w_done_nxt;
   logic              r_stall, w_stall_nxt;
   logic [WORD_W-1:0] r_dout, w_dout_nxt;
   logic              w_accept, w_we;
   logic [ADDR_W-1:0] r_idx;
   logic [WORD_W-1:0] r_wdata, w_rdata;
   logic              r_wr;
   logic              w_unused_addr;

   // Byte bit and bits above the word index alias onto the same word.
   assign w_unused_addr = ^{addr[0], addr[WORD_W-1:ADDR_W+1]};

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_stall <= 1'b0;
         r_dout  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_done  <= w_done_nxt;
         r_stall <= w_stall_nxt;
         r_dout  <= w_dout_nxt;
      end
   end

   // Request latches only move on acceptance; their reset value is irrelevant.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_idx   <= addr[ADDR_W:1];
         r_wdata <= data_in;
         r_wr    <= wr;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_done_nxt  = 1'b0;
      w_stall_nxt = r_stall;
      w_dout_nxt  = r_dout;
      w_accept    = 1'b0;
      w_we        = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable) begin
               w_accept    = 1'b1;
               w_cnt_nxt   = CNT_LOAD;
               w_state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (r_cnt != '0) begin
               w_cnt_nxt   = r_cnt - CNT_W'(1);
               w_stall_nxt = 1'b1;
            end else begin
               w_we        = r_wr;
               if (!r_wr) w_dout_nxt = w_rdata;
               w_done_nxt  = 1'b1;
               w_stall_nxt = 1'b0;
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_stall_nxt = 1'b0;
         end
      endcase
   end

   mem_word_array #(
      .ADDR_W(ADDR_W)
   ) u_array (
      .clk  (clk),
      .we   (w_we),
      .idx  (r_idx),
      .wdata(r_wdata),
      .rdata(w_rdata)
   );

   assign data_out = r_dout;
   assign done     = r_done;
   assign stall    = r_stall;
endmodule

// File: tb/tb_mem_latency_responder.sv
// Bench for mem_latency_responder: a LATENCY=4 and a LATENCY=1 instance against a word-array model.
module tb_mem_latency_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] addr [2];
   logic [15:0] din  [2];
   logic [15:0] dout [2];
   logic        en   [2];
   logic        wr   [2];
   logic        done [2];
   logic        stall[2];

   int total = 0;
   int bad   = 0;

   // Reference model: word storage, written flags and the expected read register.
   logic [15:0] m [2][1024];
   bit          v [2][1024];
   logic [15:0] exp_dout [2];
   bit          exp_known[2];

   always #5 clk = ~clk;

   mem_latency_responder #(.ADDR_W(10), .LATENCY(4)) u_dut4 (
      .clk(clk), .rst(rst), .addr(addr[0]), .data_in(din[0]), .enable(en[0]),
      .wr(wr[0]), .data_out(dout[0]), .done(done[0]), .stall(stall[0]));

   mem_latency_responder #(.ADDR_W(10), .LATENCY(1)) u_dut1 (
      .clk(clk), .rst(rst), .addr(addr[1]), .data_in(din[1]), .enable(en[1]),
      .wr(wr[1]), .data_out(dout[1]), .done(done[1]), .stall(stall[1]));

   function automatic int lat(input int s);
      return (s == 0) ? 4 : 1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One request on instance s; checks stall/done every cycle and data_out at completion.
   task automatic req(input int s, input logic [15:0] a, input logic [15:0] d,
                      input logic w, input bit hold, input string tag);
      int          l   = lat(s);
      logic [9:0]  idx = a[10:1];
      logic        exp_st, exp_dn;
      en[s] = 1'b1; addr[s] = a; din[s] = d; wr[s] = w;
      tick();
      if (!hold) begin
         en[s] = 1'b0; addr[s] = 16'($urandom); din[s] = 16'($urandom); wr[s] = 1'($urandom);
      end
      if (w) begin
         m[s][idx] = d;
         v[s][idx] = 1'b1;
      end else if (v[s][idx]) begin
         exp_dout[s]  = m[s][idx];
         exp_known[s] = 1'b1;
      end else begin
         exp_known[s] = 1'b0;
      end
      for (int k = 0; k <= l; k++) begin
         exp_st = (k >= 1 && k < l);
         exp_dn = (k == l);
         total++;
         if (stall[s] !== exp_st) begin
            bad++;
            $display("FAIL %s stall[%0d] k=%0d: got %b want %b", tag, s, k, stall[s], exp_st);
         end
         total++;
         if (done[s] !== exp_dn) begin
            bad++;
            $display("FAIL %s done[%0d] k=%0d: got %b want %b", tag, s, k, done[s], exp_dn);
         end
         if (k < l) tick();
      end
      if (exp_known[s]) begin
         total++;
         if (dout[s] !== exp_dout[s]) begin
            bad++;
            $display("FAIL %s data_out[%0d]: got %h want %h", tag, s, dout[s], exp_dout[s]);
         end
      end
      en[s] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         en[s] = 1'b1; wr[s] = 1'b1; addr[s] = 16'h0040; din[s] = 16'h5555;
      end
      repeat (2) begin
         tick();
         for (int s = 0; s < 2; s++) begin
            total++;
            if (dout[s] !== 16'h0000 || done[s] !== 1'b0 || stall[s] !== 1'b0) begin
               bad++;
               $display("FAIL reset[%0d]: got dout=%h done=%b stall=%b want 0000/0/0",
                        s, dout[s], done[s], stall[s]);
            end
         end
      end
      rst = 1'b1;
      en[0] = 1'b0; en[1] = 1'b0;
      for (int s = 0; s < 2; s++) begin
         exp_dout[s] = 16'h0000; exp_known[s] = 1'b1;
      end
      repeat (2) begin
         tick();
         for (int s = 0; s < 2; s++) begin
            total++;
            if (done[s] !== 1'b0 || stall[s] !== 1'b0) begin
               bad++;
               $display("FAIL idle[%0d]: got done=%b stall=%b want 0/0", s, done[s], stall[s]);
            end
         end
      end
   endtask

   task automatic test_write_read();
      req(0, 16'h0010, 16'hBEEF, 1'b1, 1'b0, "wr_beef");
      req(0, 16'h0010, 16'h0000, 1'b0, 1'b0, "rd_beef");
      total++;
      if (dout[0] !== 16'hBEEF) begin
         bad++;
         $display("FAIL rd_beef_const: got %h want beef", dout[0]);
      end
   endtask

   task automatic test_held();
      req(0, 16'h0020, 16'h5A5A, 1'b1, 1'b1, "held_wr");
      req(0, 16'h0020, 16'h0000, 1'b0, 1'b1, "held_rd");
      repeat (3) begin
         tick();
         total++;
         if (done[0] !== 1'b0 || stall[0] !== 1'b0) begin
            bad++;
            $display("FAIL held_after: got done=%b stall=%b want 0/0", done[0], stall[0]);
         end
      end
   endtask

   task automatic test_alias();
      req(0, 16'h0011, 16'h1234, 1'b1, 1'b0, "alias_wr");
      req(0, 16'h0010, 16'h0000, 1'b0, 1'b0, "alias_rd0");
      req(0, 16'h0810, 16'h0000, 1'b0, 1'b0, "alias_rd1");
      total++;
      if (dout[0] !== 16'h1234) begin
         bad++;
         $display("FAIL alias_const: got %h want 1234", dout[0]);
      end
   endtask

   task automatic test_reset_mid_write();
      req(0, 16'h0030, 16'h7777, 1'b1, 1'b0, "pre_30");
      req(0, 16'h0040, 16'h1111, 1'b1, 1'b0, "pre_40");
      en[0] = 1'b1; addr[0] = 16'h0030; din[0] = 16'hAAAA; wr[0] = 1'b1;
      tick();
      en[0] = 1'b0;
      tick();
      total++;
      if (stall[0] !== 1'b1) begin
         bad++;
         $display("FAIL midw_stall: got %b want 1", stall[0]);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      exp_dout[0] = 16'h0000; exp_dout[1] = 16'h0000;
      exp_known[0] = 1'b1;    exp_known[1] = 1'b1;
      total++;
      if (done[0] !== 1'b0 || stall[0] !== 1'b0 || dout[0] !== 16'h0000) begin
         bad++;
         $display("FAIL midw_reset: got done=%b stall=%b dout=%h want 0/0/0000",
                  done[0], stall[0], dout[0]);
      end
      repeat (5) begin
         tick();
         total++;
         if (done[0] !== 1'b0) begin
            bad++;
            $display("FAIL midw_nodone: got %b want 0", done[0]);
         end
      end
      // Reset held while a write is offered must not touch the array.
      rst = 1'b0;
      en[0] = 1'b1; wr[0] = 1'b1; addr[0] = 16'h0040; din[0] = 16'h5555;
      repeat (2) tick();
      rst = 1'b1; en[0] = 1'b0;
      tick();
      req(0, 16'h0030, 16'h0000, 1'b0, 1'b0, "midw_rd30");
      req(0, 16'h0040, 16'h0000, 1'b0, 1'b0, "midw_rd40");
   endtask

   task automatic test_lat1();
      req(1, 16'h0002, 16'($urandom), 1'b1, 1'b0, "l1_wr2");
      req(1, 16'h0004, 16'($urandom), 1'b1, 1'b0, "l1_wr4");
      req(1, 16'h0002, 16'h0000, 1'b0, 1'b1, "l1_rd2");
      req(1, 16'h0004, 16'h0000, 1'b0, 1'b1, "l1_rd4");
   endtask

   task automatic test_random();
      for (int s = 0; s < 2; s++)
         for (int i = 0; i < 32; i++)
            req(s, {5'($urandom), 10'(i), 1'($urandom)}, 16'($urandom), 1'b1, 1'b0, "rnd_pre");
      for (int n = 0; n < 60; n++) begin
         int s = n % 2;
         repeat ($urandom_range(0, 2)) begin
            tick();
            total++;
            if (done[s] !== 1'b0) begin
               bad++;
               $display("FAIL rnd_gap done[%0d]: got %b want 0", s, done[s]);
            end
         end
         req(s, {5'($urandom), 10'($urandom_range(0, 31)), 1'($urandom)}, 16'($urandom),
             1'($urandom), 1'($urandom), "rnd");
      end
   endtask

   initial begin
      rst = 1'b0;
      for (int s = 0; s < 2; s++) begin
         en[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; din[s] = '0;
      end
      test_reset();
      test_write_read();
      test_held();
      test_alias();
      test_reset_mid_write();
      test_lat1();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
